rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Round-robin arbiter for the single write port of the register file. The
//  register file is built from negedge-clocked, write-enabled flip-flop bits.
//  N writeback sources (ALU, load unit, mul/div) compete for that port through
//  valid/ready handshakes. One registered write is issued per cycle; writes to
//  r0 are discarded. Sits between the writeback stage and the register file.
// PARAMETERS
//  N_REQ   3   number of requesters (2..8)
//  ADDR_W  5   register address width
//  DATA_W  32  register data width
//  CNT_W   16  width of the stall statistics counter
// PORTS
//  clk        in   1             clock; arbiter state updates on posedge
//  reset      in   1             reset, asynchronous, active-high
//  req_valid  in   N_REQ         per-requester write request
//  req_addr   in   N_REQ*ADDR_W  packed destination addresses, req i at [i*ADDR_W +: ADDR_W]
//  req_data   in   N_REQ*DATA_W  packed write data, req i at [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ         one-hot accept; combinational from valid/state/busy
//  wr_busy    in   1             register file cannot take a write this cycle
//  wr_en      out  1             registered write enable to register file
//  wr_addr    out  ADDR_W        registered write address
//  wr_data    out  DATA_W        registered write data
//  wr_src     out  clog2(N_REQ)  index of the requester owning the current write
//  stall_cnt  out  CNT_W         cycles with wr_en=1 and wr_busy=1, saturating
// BEHAVIOUR
//  - Reset (async, immediate):
//    - wr_en=0, wr_addr=0, wr_data=0, wr_src=0, stall_cnt=0
//    - rr pointer last=N_REQ-1, so req0 has highest priority first
//    - req_ready=0 while reset=1
//  - Output stage FSM:
//    - EMPTY (wr_en=0)
//    - FULL (wr_en=1, outputs held stable)
//    - can_accept = EMPTY | (FULL & !wr_busy)
//  - Grant:
//    - scan valid requesters starting at (last+1) mod N_REQ
//    - first valid found is the winner
//    - req_ready[winner] = can_accept; all other ready bits 0
//    - at most one ready bit high per cycle
//  - Transfer = req_valid[i] & req_ready[i]. On the transfer posedge:
//    - last <= i
//    - addr != 0: wr_en<=1, wr_addr/wr_data/wr_src <= req i fields -> FULL
//    - addr == 0: request consumed, no write; wr_en<=0 -> EMPTY
//  - No transfer and FULL & !wr_busy: wr_en<=0 -> EMPTY; addr/data/src hold
//    last values.
//  - FULL & wr_busy: all outputs held; stall_cnt += 1, saturating at all-ones.
//  - Latency:
//    - accept at posedge k -> wr_en=1 from posedge k to posedge k+1
//    - register file captures at the negedge inside that cycle
//    - back-to-back accepts give one write per cycle
//  - Requesters hold valid/addr/data stable until ready. Dropping valid
//    without ready is a protocol error; the block takes no defined action.
//  - Writes from one requester stay in order. No cross-requester
//    same-address ordering beyond grant order.
//  - Reset mid-write: the pending write is lost and wr_en drops immediately.
//    The pointer returns to the req0-first state.
// TESTING
//  - Reset: assert reset mid-FULL -> wr_en=0 same cycle, stall_cnt=0; first
//    grant after release goes to req0.
//  - Round-robin: all 3 valid continuously, wr_busy=0 -> wr_src 0,1,2,0,1,2;
//    wr_en=1 every cycle.
//  - Backpressure: req1 wr_addr=7 data=0xA5A5A5A5, wr_busy=1 for 4 cycles ->
//    outputs held, req_ready all 0, stall_cnt=4; write retires when busy drops.
//  - r0 drop: req2 addr=0 data=0xFFFFFFFF -> req_ready[2]=1 for one cycle,
//    wr_en stays 0, next grant starts at req0.
//  - Saturation: CNT_W=4, wr_busy=1 for 20 cycles while FULL -> stall_cnt
//    sticks at 15.
//  - Randomized valid/busy vs. scoreboard: every accepted non-r0 write seen
//    exactly once, in per-source order.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback-to-register-file bus, including requester
// handshakes and the registered write port.
`default_nettype none

interface rf_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    wr_busy;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [SRC_W-1:0]        wr_src;
  logic [CNT_W-1:0]        stall_cnt;

  modport slave (
    input  req_valid, req_addr, req_data, wr_busy,
    output req_ready, wr_en, wr_addr, wr_data, wr_src, stall_cnt
  );

  modport master (
    output req_valid, req_addr, req_data, wr_busy,
    input  req_ready, wr_en, wr_addr, wr_data, wr_src, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the register file's single write
// port; one registered write per cycle, writes to r0 are consumed and dropped.
`default_nettype none

module rf_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(N_REQ);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        r_state;
  logic [SRC_W-1:0]  r_last;
  logic [SRC_W-1:0]  r_src;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall;

  logic              w_can_accept;
  logic              w_found;
  logic              w_xfer;
  logic [SRC_W-1:0]  w_win;
  logic [SRC_W:0]    w_idx;
  logic [N_REQ-1:0]  w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  assign w_can_accept = (r_state == ST_EMPTY) || !bus.wr_busy;

  // Scan starts one past the last winner and wraps; the extra index bit
  // holds the unwrapped sum before the modulo correction.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last} + (SRC_W+1)'(k);
      if (w_idx >= (SRC_W+1)'(N_REQ)) begin
        w_idx = w_idx - (SRC_W+1)'(N_REQ);
      end
      if (!w_found && bus.req_valid[w_idx[SRC_W-1:0]]) begin
        w_found                     = 1'b1;
        w_win                       = w_idx[SRC_W-1:0];
        w_grant[w_idx[SRC_W-1:0]]   = 1'b1;
      end
    end
  end

  assign w_xfer     = w_found && w_can_accept;
  assign w_sel_addr = bus.req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_sel_data = bus.req_data[w_win*DATA_W +: DATA_W];

  assign bus.req_ready = (reset || !w_can_accept) ? '0 : w_grant;
  assign bus.wr_en     = (r_state == ST_FULL);
  assign bus.wr_addr   = r_addr;
  assign bus.wr_data   = r_data;
  assign bus.wr_src    = r_src;
  assign bus.stall_cnt = r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_last  <= SRC_W'(N_REQ - 1);
      r_src   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_stall <= '0;
    end else begin
      if (w_xfer) begin
        r_last <= w_win;
        if (w_sel_addr != '0) begin
          r_state <= ST_FULL;
          r_addr  <= w_sel_addr;
          r_data  <= w_sel_data;
          r_src   <= w_win;
        end else begin
          r_state <= ST_EMPTY;
        end
      end else if (r_state == ST_FULL && !bus.wr_busy) begin
        r_state <= ST_EMPTY;
      end

      if (r_state == ST_FULL && bus.wr_busy && r_stall != {CNT_W{1'b1}}) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized scoreboard bench for the
// register-file write arbiter (16-bit and 4-bit stall counter instances).
`default_nettype none

module tb_rf_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int            src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) bus_a();
  rf_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(4))  bus_b();

  assign bus_b.req_valid = bus_a.req_valid;
  assign bus_b.req_addr  = bus_a.req_addr;
  assign bus_b.req_data  = bus_a.req_data;
  assign bus_b.wr_busy   = bus_a.wr_busy;

  rf_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  rf_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  req_t         in_q[N][$];
  exp_t         exp_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           m_last = N - 1;
  bit           m_full = 1'b0;
  int           m_stall_a = 0;
  int           m_stall_b = 0;
  logic [N-1:0] obs_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.addr = a;
    r.data = d;
    in_q[i].push_back(r);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (in_q[i].size() > 0) begin
        bus_a.req_valid[i]             = 1'b1;
        bus_a.req_addr[i*AW +: AW]     = in_q[i][0].addr;
        bus_a.req_data[i*DW +: DW]     = in_q[i][0].data;
      end else begin
        bus_a.req_valid[i]             = 1'b0;
        bus_a.req_addr[i*AW +: AW]     = '0;
        bus_a.req_data[i*DW +: DW]     = '0;
      end
    end
  endtask

  // One clock of reference behaviour: a single write slot plus a rotating
  // priority pointer, evaluated at the negedge and committed at the posedge.
  task automatic step();
    logic [N-1:0] er;
    int           win;
    bit           was_full;
    bit           busy;
    req_t         r;
    exp_t         e;
    drive_inputs();
    @(negedge clk);
    busy = bus_a.wr_busy;
    if (reset) begin
      m_full    = 1'b0;
      m_stall_a = 0;
      m_stall_b = 0;
      m_last    = N - 1;
      exp_q.delete();
    end
    er  = '0;
    win = -1;
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (win < 0 && in_q[j].size() > 0) win = j;
      end
      if (win >= 0 && (!m_full || !busy)) er[win] = 1'b1;
    end
    obs_ready = bus_a.req_ready;
    chk("req_ready", bus_a.req_ready, er);
    chk("wr_en", bus_a.wr_en, m_full);
    chk("stall_cnt16", bus_a.stall_cnt, m_stall_a);
    chk("stall_cnt4", bus_b.stall_cnt, m_stall_b);
    if (!reset) begin
      was_full = m_full;
      if (er != '0) begin
        r      = in_q[win].pop_front();
        m_last = win;
        if (r.addr != '0) begin
          e.src  = win;
          e.addr = r.addr;
          e.data = r.data;
          exp_q.push_back(e);
          m_full = 1'b1;
        end else begin
          m_full = 1'b0;
        end
      end else if (m_full && !busy) begin
        m_full = 1'b0;
      end
      if (was_full && busy) begin
        if (m_stall_a < 65535) m_stall_a++;
        if (m_stall_b < 15)    m_stall_b++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus_a.wr_busy = 1'b0;
    while ((in_q[0].size() + in_q[1].size() + in_q[2].size() + exp_q.size() > 0 || m_full)
           && guard < 200) begin
      step();
      guard++;
    end
    chk("drain_bounded", guard < 200, 1);
  endtask

  // Retiring writes are matched in order against the grant-order queue.
  always @(negedge clk) begin
    if (!reset && bus_a.wr_en && !bus_a.wr_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got src %0d addr %0h expected no write",
                 bus_a.wr_src, bus_a.wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_src", bus_a.wr_src, mon_e.src);
        chk("wr_addr", bus_a.wr_addr, mon_e.addr);
        chk("wr_data", bus_a.wr_data, mon_e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus_a.wr_busy = 1'b0;
    drive_inputs();

    // Reset state
    step();
    chk("rst_wr_en", bus_a.wr_en, 0);
    chk("rst_wr_addr", bus_a.wr_addr, 0);
    chk("rst_wr_data", bus_a.wr_data, 0);
    chk("rst_wr_src", bus_a.wr_src, 0);
    chk("rst_ready", bus_a.req_ready, 0);
    reset = 1'b0;

    // Round-robin with all requesters continuously valid
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) push_req(i, AW'(1 + r*N + i), $urandom);
    end
    for (int r = 0; r < 6; r++) begin
      step();
      chk("rr_wr_en", bus_a.wr_en, 1);
      chk("rr_src", bus_a.wr_src, r % N);
    end
    drain();

    // Reset while a write is held under backpressure
    push_req(1, 5'd9, 32'h0000_1234);
    step();
    bus_a.wr_busy = 1'b1;
    step();
    step();
    chk("pre_rst_stall", bus_a.stall_cnt, 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", bus_a.wr_en, 0);
    chk("mid_rst_stall", bus_a.stall_cnt, 0);
    bus_a.wr_busy = 1'b0;
    step();
    reset = 1'b0;
    push_req(2, 5'd10, $urandom);
    push_req(1, 5'd11, $urandom);
    push_req(0, 5'd12, $urandom);
    step();
    chk("post_rst_src", bus_a.wr_src, 0);
    drain();

    // Backpressure
    do_reset();
    push_req(1, 5'd7, 32'hA5A5_A5A5);
    step();
    chk("bp_accept", bus_a.wr_en, 1);
    bus_a.wr_busy = 1'b1;
    push_req(0, 5'd3, 32'h0000_0011);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_ready_zero", obs_ready, 0);
      chk("bp_hold_addr", bus_a.wr_addr, 7);
      chk("bp_hold_data", bus_a.wr_data, 32'hA5A5_A5A5);
      chk("bp_hold_src", bus_a.wr_src, 1);
    end
    chk("bp_stall4", bus_a.stall_cnt, 4);
    bus_a.wr_busy = 1'b0;
    step();
    chk("bp_next_src", bus_a.wr_src, 0);
    drain();

    // Write to r0 is consumed without a register-file write
    do_reset();
    push_req(2, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("r0_ready", obs_ready, 3'b100);
    chk("r0_no_write", bus_a.wr_en, 0);
    step();
    chk("r0_ready_once", obs_ready, 0);
    push_req(1, 5'd20, $urandom);
    push_req(0, 5'd21, $urandom);
    step();
    chk("r0_next_src", bus_a.wr_src, 0);
    drain();

    // Stall counter saturation
    do_reset();
    push_req(0, 5'd3, 32'hDEAD_BEEF);
    step();
    bus_a.wr_busy = 1'b1;
    repeat (20) step();
    chk("sat_cnt4", bus_b.stall_cnt, 15);
    chk("sat_cnt16", bus_a.stall_cnt, 20);
    drain();

    // Randomized traffic and backpressure
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (in_q[i].size() < 2 && $urandom_range(0, 2) == 0) begin
          push_req(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                   $urandom);
        end
      end
      bus_a.wr_busy = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
